// File: rtl/pri_arb4.sv
// Four-requester arbiter with registered one-hot grant, {valid,idx} code and hold-limit timeout.
// Define PRI_ARB4_ROUND_ROBIN_EN for rotating-pointer arbitration; default is fixed priority with one-shot timeout mask.
module pri_arb4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       release_i,
    output logic [3:0] gnt,
    output logic [2:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    gnt_nx;
    logic [2:0]    gnt_id_nx;
    logic          busy_nx;
    logic          timeout_nx;
    logic [1:0]    win_idx;
    logic          owner_req;
    logic          hit_limit;

`ifdef PRI_ARB4_ROUND_ROBIN_EN
    logic [1:0] ptr, ptr_nx;
    logic [1:0] probe;
    logic       found;

    // Ascending search from the pointer; 2-bit addition provides the wrap from 3 to 0.
    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        probe   = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            probe = ptr + 2'(k);
            if (!found && req[probe]) begin
                win_idx = probe;
                found   = 1'b1;
            end
        end
    end
`else
    logic [3:0] mask, mask_nx;
    logic [3:0] cand;

    // A lone masked requester is still served rather than left idle.
    always_comb begin
        cand = req & ~mask;
        if (cand == '0) begin
            cand = req;
        end
        win_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (cand[i]) begin
                win_idx = 2'(i);
            end
        end
    end
`endif

    assign owner_req = req[gnt_id[1:0]];
    assign hit_limit = (cnt == LIMIT);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        gnt_nx     = gnt;
        gnt_id_nx  = gnt_id;
        busy_nx    = busy;
        timeout_nx = 1'b0;
`ifdef PRI_ARB4_ROUND_ROBIN_EN
        ptr_nx     = ptr;
`else
        mask_nx    = mask;
`endif
        case (state)
            IDLE: begin
                if (req != '0) begin
                    state_nx  = GRANT;
                    cnt_nx    = '0;
                    gnt_nx    = 4'b0001 << win_idx;
                    gnt_id_nx = {1'b1, win_idx};
                    busy_nx   = 1'b1;
`ifdef PRI_ARB4_ROUND_ROBIN_EN
                    ptr_nx    = win_idx + 2'd1;
`else
                    mask_nx   = '0;
`endif
                end
            end
            GRANT: begin
                if (!owner_req || release_i || hit_limit) begin
                    state_nx  = IDLE;
                    cnt_nx    = '0;
                    gnt_nx    = '0;
                    gnt_id_nx = '0;
                    busy_nx   = 1'b0;
                    if (hit_limit && owner_req) begin
                        timeout_nx = 1'b1;
`ifndef PRI_ARB4_ROUND_ROBIN_EN
                        mask_nx    = gnt;
`endif
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx  = IDLE;
                cnt_nx    = '0;
                gnt_nx    = '0;
                gnt_id_nx = '0;
                busy_nx   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
`ifdef PRI_ARB4_ROUND_ROBIN_EN
            ptr     <= '0;
`else
            mask    <= '0;
`endif
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            gnt     <= gnt_nx;
            gnt_id  <= gnt_id_nx;
            busy    <= busy_nx;
            timeout <= timeout_nx;
`ifdef PRI_ARB4_ROUND_ROBIN_EN
            ptr     <= ptr_nx;
`else
            mask    <= mask_nx;
`endif
        end
    end

endmodule

// File: tb/tb_pri_arb4.sv
// Bench for pri_arb4: directed steps for the stated scenarios, then random traffic against a behavioural model.
// Follows PRI_ARB4_ROUND_ROBIN_EN to select the arbitration rule and hold limit.
module tb_pri_arb4;

`ifdef PRI_ARB4_ROUND_ROBIN_EN
    localparam int unsigned MH = 1;
`else
    localparam int unsigned MH = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       release_i = 1'b0;
    logic [3:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    pri_arb4 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .release_i (release_i),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: owner index (-1 = none), cycles held so far, masked index, rotation pointer.
    int   m_owner = -1;
    int   m_held  = 0;
    int   m_mask  = -1;
    int   m_ptr   = 0;
    logic m_to    = 1'b0;

    function automatic void model_reset();
        m_owner = -1;
        m_held  = 0;
        m_mask  = -1;
        m_ptr   = 0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_step(input logic [3:0] r, input logic rel);
        int w;
        w    = -1;
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (r != 4'b0000) begin
`ifdef PRI_ARB4_ROUND_ROBIN_EN
                for (int k = 0; k < 4; k++)
                    if (w < 0 && r[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                m_ptr = (w + 1) % 4;
`else
                for (int i = 3; i >= 0; i--)
                    if (w < 0 && r[i] && i != m_mask) w = i;
                for (int i = 3; i >= 0; i--)
                    if (w < 0 && r[i]) w = i;
                m_mask = -1;
`endif
                m_owner = w;
                m_held  = 1;
            end
        end else if (!r[m_owner] || rel || m_held == int'(MH)) begin
            if (r[m_owner] && m_held == int'(MH)) begin
                m_to   = 1'b1;
                m_mask = m_owner;
            end
            m_owner = -1;
        end else begin
            m_held++;
        end
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
            $error("%s differs", tag);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [2:0] id,
                              input logic b, input logic to);
        cmp({tag, "_gnt"},     32'(gnt),     32'(g));
        cmp({tag, "_gnt_id"},  32'(gnt_id),  32'(id));
        cmp({tag, "_busy"},    32'(busy),    32'(b));
        cmp({tag, "_timeout"}, 32'(timeout), 32'(to));
    endtask

    task automatic expect_model(input string tag);
        logic [3:0] g;
        logic [2:0] id;
        g  = '0;
        id = '0;
        if (m_owner >= 0) begin
            g  = 4'b0001 << m_owner;
            id = {1'b1, 2'(m_owner)};
        end
        expect_out(tag, g, id, m_owner >= 0, m_to);
    endtask

    task automatic step(input logic [3:0] r, input logic rel);
        req       = r;
        release_i = rel;
        @(posedge clk);
        #1;
    endtask

    int unsigned run;

    initial begin
        // Reset held low with all requests asserted.
        rst_n = 1'b0;
        req   = 4'b1111;
        #12;
        expect_out("rst_hold", 4'b0000, 3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        expect_out("rst_hold_edge", 4'b0000, 3'b000, 1'b0, 1'b0);
        rst_n = 1'b1;

`ifndef PRI_ARB4_ROUND_ROBIN_EN
        step(4'b1111, 1'b0);
        expect_out("t1_first", 4'b1000, 3'b111, 1'b1, 1'b0);
        step(4'b0000, 1'b0);
        expect_out("t1_drop", 4'b0000, 3'b000, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            step(4'b0110, 1'b0);
            expect_out("t2_hold2", 4'b0100, 3'b110, 1'b1, 1'b0);
        end
        step(4'b0010, 1'b0);
        expect_out("t2_dead", 4'b0000, 3'b000, 1'b0, 1'b0);
        step(4'b0010, 1'b0);
        expect_out("t2_next", 4'b0010, 3'b101, 1'b1, 1'b0);
        step(4'b0000, 1'b0);
        expect_out("t2_end", 4'b0000, 3'b000, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            step(4'b1001, 1'b0);
            expect_out("t3_hold3", 4'b1000, 3'b111, 1'b1, 1'b0);
        end
        step(4'b1001, 1'b0);
        expect_out("t3_timeout3", 4'b0000, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(4'b1001, 1'b0);
            expect_out("t3_masked0", 4'b0001, 3'b100, 1'b1, 1'b0);
        end
        step(4'b1001, 1'b0);
        expect_out("t3_timeout0", 4'b0000, 3'b000, 1'b0, 1'b1);
        step(4'b1001, 1'b0);
        expect_out("t3_back3", 4'b1000, 3'b111, 1'b1, 1'b0);
        step(4'b0000, 1'b0);
        expect_out("t3_end", 4'b0000, 3'b000, 1'b0, 1'b0);

        step(4'b0001, 1'b0);
        expect_out("t4_c1", 4'b0001, 3'b100, 1'b1, 1'b0);
        step(4'b0001, 1'b0);
        expect_out("t4_c2", 4'b0001, 3'b100, 1'b1, 1'b0);
        step(4'b0001, 1'b1);
        expect_out("t4_release", 4'b0000, 3'b000, 1'b0, 1'b0);
        step(4'b0001, 1'b0);
        expect_out("t4_regrant", 4'b0001, 3'b100, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("t4_async_rst", 4'b0000, 3'b000, 1'b0, 1'b0);
`else
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 1'b0);
            expect_out("t5_rr_grant", 4'b0001 << (k % 4), {1'b1, 2'(k % 4)}, 1'b1, 1'b0);
            if (k < 4) begin
                step(4'b1111, 1'b0);
                expect_out("t5_rr_dead", 4'b0000, 3'b000, 1'b0, 1'b1);
            end
        end
        step(4'b0000, 1'b0);
        expect_out("t5_end", 4'b0000, 3'b000, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("t5_async_rst", 4'b0000, 3'b000, 1'b0, 1'b0);
`endif

        // Random traffic against the model, with one mid-cycle asynchronous reset.
        rst_n = 1'b0;
        model_reset();
        #3;
        rst_n = 1'b1;
        run = 0;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            release_i = ($urandom_range(0, 9) == 0);
            @(posedge clk);
            model_step(req, release_i);
            #1;
            expect_model("rand");
            cmp("rand_onehot", 32'($countones(gnt) <= 1), 32'd1);
            cmp("rand_id_valid", 32'(gnt_id[2]), 32'(|gnt));
            run = (gnt != '0) ? run + 1 : 0;
            cmp("rand_hold_limit", 32'(run <= MH), 32'd1);
            if (n == 5000) begin
                #2;
                rst_n = 1'b0;
                #1;
                expect_out("rand_async_rst", 4'b0000, 3'b000, 1'b0, 1'b0);
                model_reset();
                run = 0;
                #1;
                rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
